sensor_scanner: RTL and testbench

- Sequential acquisition stage directly upstream of the temperature averaging/display path.
- Polls 5 temperature sensors one at a time over a shared 8-bit request/acknowledge bus, with a per-sensor timeout.
- Assembles the 40-bit packed data word and 5-bit enable mask that the averaging path consumes.
- Publishes each completed frame atomically with a one-cycle valid pulse.

---
 rtl/sensor_scanner_pkg.sv | 22 ++
 rtl/sensor_scanner_timeout_counter.sv | 28 ++
 rtl/sensor_scanner.sv | 123 ++++++++++++
 tb/tb_sensor_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_scanner_pkg.sv
// Shared constants, state encodings and frame payload for the sensor acquisition path.
package sensor_scanner_pkg;

    localparam int unsigned NUM_SENSORS = 5;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TIMEOUT     = 15;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned FRAME_W     = NUM_SENSORS * DATA_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One complete frame: packed readings (sensor0 in the low byte) plus response mask.
    typedef struct packed {
        logic [FRAME_W-1:0]     data;
        logic [NUM_SENSORS-1:0] en;
    } frame_t;

endpackage

// File: rtl/sensor_scanner_timeout_counter.sv
// Per-sensor REQ-cycle counter; expired_c flags the LIMIT-th REQ cycle.
module sensor_timeout_counter
    import sensor_scanner_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    logic [CNT_W-1:0] r_count;

    // Count REQ cycles without an ack; clear has priority over enable.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count holds the number of previous REQ cycles, so LIMIT-1 marks the LIMIT-th one.
    assign expired_c = (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/sensor_scanner.sv
// Polls each sensor over a shared req/ack bus and publishes whole frames atomically.
module sensor_scanner
    import sensor_scanner_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic [SEL_W-1:0]       sens_sel_o,
    output logic                   sens_req_o,
    input  logic                   sens_ack_i,
    input  logic [DATA_W-1:0]      sens_data_i,
    output logic [FRAME_W-1:0]     sensors_data_o,
    output logic [NUM_SENSORS-1:0] sensors_en_o,
    output logic                   frame_valid_o,
    output logic                   busy_o
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    frame_t           r_shadow;
    frame_t           w_shadow_nxt;
    frame_t           r_frame;
    logic             r_req;
    logic             r_busy;
    logic             r_valid;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_expired;

    sensor_timeout_counter #(
        .LIMIT (P_TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_cnt_clr),
        .en_i      (w_cnt_en),
        .expired_c (w_expired)
    );

    // State, index and shadow frame registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_sel    <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    // Next-state, shadow capture and counter control.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_REQ;
                    w_sel_nxt   = '0;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_REQ: begin
                w_cnt_en = !sens_ack_i;
                if (sens_ack_i || w_expired) begin
                    w_state_nxt = ST_GAP;
                    for (int i = 0; i < NUM_SENSORS; i++) begin
                        if (r_sel == SEL_W'(i)) begin
                            w_shadow_nxt.data[i*DATA_W +: DATA_W] = sens_ack_i ? sens_data_i : '0;
                            w_shadow_nxt.en[i]                    = sens_ack_i;
                        end
                    end
                end
            end
            ST_GAP: begin
                w_cnt_clr = 1'b1;
                if (r_sel < SEL_W'(NUM_SENSORS - 1)) begin
                    w_sel_nxt   = r_sel + SEL_W'(1);
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered bus/status outputs and atomic frame publish on DONE entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_frame <= '0;
        end else begin
            r_req   <= (w_state_nxt == ST_REQ);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_valid <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) begin
                r_frame <= w_shadow_nxt;
            end
        end
    end

    assign sens_sel_o     = r_sel;
    assign sens_req_o     = r_req;
    assign busy_o         = r_busy;
    assign frame_valid_o  = r_valid;
    assign sensors_data_o = r_frame.data;
    assign sensors_en_o   = r_frame.en;

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed bench for sensor_scanner: frame contents, latency, timeouts and reset/start handling.
module tb_sensor_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ack;
    logic [7:0]  sdata;
    logic [2:0]  sens_sel_o;
    logic        sens_req_o;
    logic [39:0] sensors_data_o;
    logic [4:0]  sensors_en_o;
    logic        frame_valid_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    // Scan configuration: reading per sensor and REQ cycle on which it acks (0 = never).
    logic [7:0] g_data [5];
    int         g_ack_at [5];
    bit         g_spurious;
    int         g_start_pulse_at;
    logic [39:0] prev_data;
    logic [4:0]  prev_en;

    // Scan observations.
    int r_valid_cycle;
    int r_pulses;
    int r_req [5];
    bit r_held_ok;

    sensor_scanner dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .sens_sel_o     (sens_sel_o),
        .sens_req_o     (sens_req_o),
        .sens_ack_i     (ack),
        .sens_data_i    (sdata),
        .sensors_data_o (sensors_data_o),
        .sensors_en_o   (sensors_en_o),
        .frame_valid_o  (frame_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Start a scan (start sampled at edge 0) and act as the sensors; cycle n follows edge n-1.
    task automatic run_scan();
        int rc [5];
        for (int i = 0; i < 5; i++) rc[i] = 0;
        r_valid_cycle = -1;
        r_pulses      = 0;
        r_held_ok     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        ack   = g_spurious;
        sdata = 8'hEE;
        @(posedge clk);
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            start = (cyc == g_start_pulse_at);
            if (frame_valid_o === 1'b1) begin
                r_pulses++;
                if (r_valid_cycle < 0) r_valid_cycle = cyc;
            end else if (r_valid_cycle < 0 &&
                         (sensors_data_o !== prev_data || sensors_en_o !== prev_en)) begin
                r_held_ok = 1'b0;
            end
            if (sens_req_o === 1'b1) begin
                rc[int'(sens_sel_o)]++;
                ack   = (g_ack_at[int'(sens_sel_o)] != 0) &&
                        (rc[int'(sens_sel_o)] == g_ack_at[int'(sens_sel_o)]);
                sdata = ack ? g_data[int'(sens_sel_o)] : 8'h5A;
            end else begin
                ack   = g_spurious;
                sdata = 8'hEE;
            end
            if (r_valid_cycle >= 0 && cyc >= r_valid_cycle + 4) break;
        end
        start = 1'b0;
        ack   = 1'b0;
        for (int i = 0; i < 5; i++) r_req[i] = rc[i];
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0; sdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sensors_data_o !== 40'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b0) begin failures++; $display("FAIL reset_en: got %b expected 00000", sensors_en_o); end
        checks++; if (frame_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", frame_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (sens_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", sens_req_o); end
        checks++; if (sens_sel_o !== 3'd0) begin failures++; $display("FAIL reset_sel: got %0d expected 0", sens_sel_o); end
        rst = 1'b0;
        prev_data = 40'h0; prev_en = 5'b0;
    endtask

    task automatic test_all_ack();
        g_data = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
        g_ack_at = '{1, 1, 1, 1, 1};
        g_spurious = 1'b0; g_start_pulse_at = -1;
        run_scan();
        checks++; if (r_valid_cycle != 11) begin failures++; $display("FAIL ack_latency: got %0d expected 11", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'h1817161514) begin failures++; $display("FAIL ack_data: got %h expected 1817161514", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b11111) begin failures++; $display("FAIL ack_en: got %b expected 11111", sensors_en_o); end
        checks++; if (r_pulses != 1) begin failures++; $display("FAIL ack_pulses: got %0d expected 1", r_pulses); end
        checks++; if (!r_held_ok) begin failures++; $display("FAIL ack_held: got changed expected held"); end
        prev_data = 40'h1817161514; prev_en = 5'b11111;
    endtask

    task automatic test_sensor_timeout();
        g_data = '{8'd30, 8'd30, 8'd30, 8'd30, 8'd30};
        g_ack_at = '{1, 1, 0, 1, 1};
        g_spurious = 1'b0; g_start_pulse_at = -1;
        run_scan();
        checks++; if (r_valid_cycle != 25) begin failures++; $display("FAIL to2_latency: got %0d expected 25", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'h1E1E001E1E) begin failures++; $display("FAIL to2_data: got %h expected 1e1e001e1e", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b11011) begin failures++; $display("FAIL to2_en: got %b expected 11011", sensors_en_o); end
        checks++; if (r_req[2] != 15) begin failures++; $display("FAIL to2_req_cycles: got %0d expected 15", r_req[2]); end
        checks++; if (!r_held_ok) begin failures++; $display("FAIL to2_held: got changed expected held"); end
        prev_data = 40'h1E1E001E1E; prev_en = 5'b11011;
    endtask

    task automatic test_all_timeout();
        g_data = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        g_ack_at = '{0, 0, 0, 0, 0};
        g_spurious = 1'b0; g_start_pulse_at = -1;
        run_scan();
        checks++; if (r_valid_cycle != 81) begin failures++; $display("FAIL toall_latency: got %0d expected 81", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'h0) begin failures++; $display("FAIL toall_data: got %h expected 0", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b00000) begin failures++; $display("FAIL toall_en: got %b expected 00000", sensors_en_o); end
        checks++; if (!r_held_ok) begin failures++; $display("FAIL toall_held: got changed expected held until cycle 81"); end
        checks++; if (r_req[4] != 15) begin failures++; $display("FAIL toall_req_cycles: got %0d expected 15", r_req[4]); end
        prev_data = 40'h0; prev_en = 5'b0;
    endtask

    task automatic test_ack_on_last_cycle();
        g_data = '{8'd50, 8'd1, 8'd2, 8'd3, 8'd4};
        g_ack_at = '{15, 1, 1, 1, 1};
        g_spurious = 1'b1; g_start_pulse_at = -1;
        run_scan();
        checks++; if (r_valid_cycle != 25) begin failures++; $display("FAIL last_latency: got %0d expected 25", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'h0403020132) begin failures++; $display("FAIL last_data: got %h expected 0403020132", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b11111) begin failures++; $display("FAIL last_en: got %b expected 11111", sensors_en_o); end
        checks++; if (r_pulses != 1) begin failures++; $display("FAIL last_pulses: got %0d expected 1", r_pulses); end
        prev_data = 40'h0403020132; prev_en = 5'b11111;
        g_spurious = 1'b0;
    endtask

    task automatic test_start_during_scan();
        g_data = '{8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        g_ack_at = '{1, 1, 1, 1, 1};
        g_spurious = 1'b0; g_start_pulse_at = 4;
        run_scan();
        g_start_pulse_at = -1;
        checks++; if (r_pulses != 1) begin failures++; $display("FAIL midstart_pulses: got %0d expected 1", r_pulses); end
        checks++; if (r_valid_cycle != 11) begin failures++; $display("FAIL midstart_latency: got %0d expected 11", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'h0D0C0B0A09) begin failures++; $display("FAIL midstart_data: got %h expected 0d0c0b0a09", sensors_data_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midstart_idle: got busy %b expected 0", busy_o); end
        prev_data = 40'h0D0C0B0A09; prev_en = 5'b11111;
    endtask

    task automatic test_reset_mid_scan();
        bit hit;
        int spurious_valid;
        hit = 1'b0;
        spurious_valid = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (sens_req_o === 1'b1 && sens_sel_o === 3'd3) begin
                hit = 1'b1;
                ack = 1'b0;
                rst = 1'b1;
                break;
            end
            ack   = (sens_req_o === 1'b1);
            sdata = 8'h77;
        end
        checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach: got no REQ for sensor 3 expected one"); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sensors_data_o !== 40'h0) begin failures++; $display("FAIL rstmid_data: got %h expected 0", sensors_data_o); end
        checks++; if (sensors_en_o !== 5'b0) begin failures++; $display("FAIL rstmid_en: got %b expected 00000", sensors_en_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
        checks++; if (sens_req_o !== 1'b0 || frame_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_req_valid: got req=%b valid=%b expected 0 0", sens_req_o, frame_valid_o); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_valid_o !== 1'b0) spurious_valid++;
        end
        checks++; if (spurious_valid != 0) begin failures++; $display("FAIL rstmid_novalid: got %0d pulses expected 0", spurious_valid); end
        prev_data = 40'h0; prev_en = 5'b0;
        g_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        g_ack_at = '{1, 2, 1, 3, 1};
        g_spurious = 1'b0; g_start_pulse_at = -1;
        run_scan();
        checks++; if (r_valid_cycle != 14) begin failures++; $display("FAIL rstmid_fresh_latency: got %0d expected 14", r_valid_cycle); end
        checks++; if (sensors_data_o !== 40'hA4A3A2A1A0 || sensors_en_o !== 5'b11111) begin failures++; $display("FAIL rstmid_fresh_frame: got %h/%b expected a4a3a2a1a0/11111", sensors_data_o, sensors_en_o); end
    endtask

    initial begin
        g_start_pulse_at = -1;
        g_spurious = 1'b0;
        test_reset();
        test_all_ack();
        test_sensor_timeout();
        test_all_timeout();
        test_ack_on_last_cycle();
        test_start_during_scan();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
